// File: rtl/spi_reg_slave.sv
// SPI target with a small register file: one 16-bit frame per access ({rw, addr[6:0]}, data).
// spi_clk is oversampled in the clk domain; all SPI pins arrive already synchronized.
module spi_reg_slave #(
  parameter int NUM_CFG    = 8,
  parameter int NUM_STATUS = 8,
  parameter int REG_WIDTH  = 8
) (
  input  logic                            clk,
  input  logic                            rstb,
  input  logic                            ena,
  input  logic [1:0]                      mode,
  input  logic                            spi_cs_n,
  input  logic                            spi_clk,
  input  logic                            spi_mosi,
  output logic                            spi_miso,
  output logic [NUM_CFG*REG_WIDTH-1:0]    config_regs,
  input  logic [NUM_STATUS*REG_WIDTH-1:0] status_regs,
  output logic                            wr_strobe,
  output logic [6:0]                      wr_addr
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  state_t                              state;
  logic                                spi_clk_d;
  logic [1:0]                          mode_q;
  logic [3:0]                          cnt;
  logic [6:0]                          cmd_sr;
  logic [REG_WIDTH-1:0]                rx_sr;
  logic [REG_WIDTH-1:0]                tx_sr;
  logic                                rw_q;
  logic [6:0]                          addr_q;
  logic [NUM_CFG-1:0][REG_WIDTH-1:0]   cfg;

  logic rise, fall, leading, trailing, sample_edge;
  logic [6:0]           cmd_addr;
  logic [REG_WIDTH-1:0] rx_next;
  logic [REG_WIDTH-1:0] rd_data;
  logic                 cfg_hit;

  assign rise        = spi_clk & ~spi_clk_d;
  assign fall        = ~spi_clk & spi_clk_d;
  assign leading     = mode_q[1] ? fall : rise;
  assign trailing    = mode_q[1] ? rise : fall;
  assign sample_edge = mode_q[0] ? trailing : leading;

  // Address is complete on the 8th edge: 6 bits already in cmd_sr plus the live MOSI bit.
  assign cmd_addr = {cmd_sr[5:0], spi_mosi};
  assign rx_next  = {rx_sr[REG_WIDTH-2:0], spi_mosi};
  assign config_regs = cfg;

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_CFG; i++)
      if (cmd_addr == 7'(i)) rd_data = cfg[i];
    for (int i = 0; i < NUM_STATUS; i++)
      if (cmd_addr == 7'(NUM_CFG + i)) rd_data = status_regs[i*REG_WIDTH +: REG_WIDTH];
  end

  always_comb begin
    cfg_hit = 1'b0;
    for (int i = 0; i < NUM_CFG; i++)
      if (addr_q == 7'(i)) cfg_hit = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state     <= IDLE;
      spi_clk_d <= spi_clk;
      mode_q    <= '0;
      cnt       <= '0;
      cmd_sr    <= '0;
      rx_sr     <= '0;
      tx_sr     <= '0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      cfg       <= '0;
      spi_miso  <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
    end else if (ena) begin
      spi_clk_d <= spi_clk;
      wr_strobe <= 1'b0;
      if (spi_cs_n) begin
        // CS high wins over everything, including a coincident final edge.
        state    <= IDLE;
        cnt      <= '0;
        spi_miso <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state    <= CMD;
            cnt      <= '0;
            mode_q   <= mode;
            spi_miso <= 1'b0;
          end
          CMD: begin
            if (sample_edge) begin
              cmd_sr <= {cmd_sr[5:0], spi_mosi};
              cnt    <= cnt + 4'd1;
              if (cnt == 4'd7) begin
                rw_q     <= cmd_sr[6];
                addr_q   <= cmd_addr;
                tx_sr    <= cmd_sr[6] ? '0 : rd_data;
                spi_miso <= ~cmd_sr[6] & rd_data[REG_WIDTH-1];
                state    <= DATA;
              end
            end
          end
          DATA: begin
            if (sample_edge) begin
              rx_sr    <= rx_next;
              tx_sr    <= {tx_sr[REG_WIDTH-2:0], 1'b0};
              cnt      <= cnt + 4'd1;
              // MISO moves with tx_sr so the next bit is out one clk after the edge.
              spi_miso <= tx_sr[REG_WIDTH-2];
              if (cnt == 4'd15) begin
                state    <= DONE;
                spi_miso <= 1'b0;
                if (rw_q && cfg_hit) begin
                  for (int i = 0; i < NUM_CFG; i++)
                    if (addr_q == 7'(i)) cfg[i] <= rx_next;
                  wr_strobe <= 1'b1;
                  wr_addr   <= addr_q;
                end
              end
            end
          end
          DONE: spi_miso <= 1'b0;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
